addsub_inverse: RTL and testbench
=================================

ADDSUB_INVERSE -- requirements
Module: addsub_inverse

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits.
REQ-002 Parameter: CNT_W, default 8, width of the completed-transaction counter.
REQ-003 Port: clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_ni  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid_i  input  1  upstream has a valid {y_i, b_i, sel_i} triple.
REQ-006 Port: in_ready_o  output  1  block accepts the input triple this cycle.
REQ-007 Port: y_i  input  WIDTH  forward result to invert (y = sel ? a+b : a-b).
REQ-008 Port: b_i  input  WIDTH  second operand used in the forward operation.
REQ-009 Port: sel_i  input  1  forward operation flag: 1 = add, 0 = subtract.
REQ-010 Port: out_valid_o  output  1  a_o holds a valid recovered operand.
REQ-011 Port: out_ready_i  input  1  downstream accepts a_o this cycle.
REQ-012 Port: a_o  output  WIDTH  recovered first operand.
REQ-013 Port: txn_cnt_o  output  CNT_W  count of completed output handshakes.

Function
REQ-014 Recovery SHALL be a_o = sel ? (y - b) : (y + b), computed modulo 2^WIDTH, carry/borrow discarded, no overflow flag.
REQ-015 Input handshake SHALL occur when in_valid_i && in_ready_o on a rising edge; output handshake when out_valid_o && out_ready_i.
REQ-016 Datapath SHALL be two register stages: S1 captures {y, b, sel, valid}; S2 holds {a, valid}, a computed from S1 contents when S1 advances into S2.
REQ-017 S2 SHALL advance (load) when !S2.valid || out_ready_i; S1 SHALL advance when !S1.valid || S2 advances.
REQ-018 in_ready_o SHALL equal !S1.valid || (S2 advance condition); combinational path from out_ready_i to in_ready_o is permitted.
REQ-019 Latency SHALL be exactly 2 cycles from input handshake to out_valid_o high with out_ready_i held high.
REQ-020 Throughput SHALL be one transaction per cycle with out_ready_i held high and in_valid_i continuously high.
REQ-021 Under out_ready_i low, a_o and out_valid_o SHALL hold stable until handshake; at most 2 transactions buffered, then in_ready_o low.
REQ-022 Outputs SHALL appear in input-handshake order; no transaction lost or duplicated under any ready/valid pattern.
REQ-023 out_valid_o SHALL NOT depend combinationally on in_valid_i.
REQ-024 txn_cnt_o SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-025 Simultaneous input and output handshake in one cycle SHALL both complete; occupancy unchanged when pipeline full.
REQ-026 Input fields SHALL be ignored when in_valid_i is low; S1 not loaded with a valid entry.

Reset
REQ-027 On rst_ni low, asynchronously: S1.valid=0, S2.valid=0, out_valid_o=0, a_o=0, txn_cnt_o=0.
REQ-028 in_ready_o SHALL be 1 during and immediately after reset.
REQ-029 Reset mid-operation SHALL discard all buffered transactions; no output handshake for them after release.
REQ-030 Deassertion of rst_ni SHALL take effect on the next rising edge; first input acceptable on that edge.

Verification
REQ-031 Directed: y=6,b=2,sel=1 -> a_o=4; y=2,b=2,sel=0 -> a_o=4; y=10,b=3,sel=1 -> a_o=7; y=4,b=3,sel=0 -> a_o=7; each 2 cycles after accept.
REQ-032 Wrap: y=1,b=3,sel=1 -> a_o=14; y=15,b=2,sel=0 -> a_o=1 (WIDTH=4).
REQ-033 Backpressure: out_ready_i=0, push 3 triples -> first two accepted, in_ready_o=0 on third; raise out_ready_i -> outputs 4,4,7 in order, a_o stable while stalled.
REQ-034 Streaming: 20 back-to-back triples, out_ready_i=1 -> 20 outputs on consecutive cycles, txn_cnt_o=20.
REQ-035 Reset mid-op: 2 entries buffered, pulse rst_ni low -> out_valid_o=0, txn_cnt_o=0 immediately, no stale output afterwards.
REQ-036 Counter wrap: 256 completed handshakes (CNT_W=8) -> txn_cnt_o=0; every output checked against a self-checking model of REQ-014.

Source files
------------

// File: rtl/addsub_inverse.sv
`default_nettype none
// ============================================================================
// addsub_inverse : two-stage ready/valid pipeline recovering a from y = a +/- b
// Revision 1.0
// ============================================================================
module addsub_inverse #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [CNT_W-1:0] txn_cnt_o
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_y;
  logic [WIDTH-1:0] s1_b;
  logic             s1_sel;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_a;
  logic [CNT_W-1:0] txn_cnt;

  logic             s2_adv;
  logic             s1_adv;
  logic             out_hs;
  logic [WIDTH-1:0] a_next;

  // Each stage loads whenever it is empty or its contents move on this edge.
  assign s2_adv = !s2_valid || out_ready_i;
  assign s1_adv = !s1_valid || s2_adv;
  assign out_hs = s2_valid && out_ready_i;

  // Inverse of the forward op; carry/borrow drop out through the WIDTH-bit result.
  assign a_next = s1_sel ? (s1_y - s1_b) : (s1_y + s1_b);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_b     <= '0;
      s1_sel   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_y   <= y_i;
        s1_b   <= b_i;
        s1_sel <= sel_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a <= a_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txn_cnt <= '0;
    end else if (out_hs) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid;
  assign a_o         = s2_a;
  assign txn_cnt_o   = txn_cnt;

endmodule
`default_nettype wire

// File: tb/tb_addsub_inverse.sv
`default_nettype none
// ============================================================================
// tb_addsub_inverse : table-driven and sequence checks for addsub_inverse
// Revision 1.0
// ============================================================================
module tb_addsub_inverse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y;
  logic [3:0] b;
  logic       sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] a;
  logic [7:0] txn_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] y;
    logic [3:0] b;
    logic       sel;
    logic [3:0] a;
  } vec_t;

  vec_t vecs[6];

  logic [3:0] exp_q[$];
  int out_n;
  int in_n;
  int cyc;
  int first_out;
  int last_out;

  addsub_inverse #(.WIDTH(4), .CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .y_i         (y),
    .b_i         (b),
    .sel_i       (sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .a_o         (a),
    .txn_cnt_o   (txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] fy, input logic [3:0] fb,
                                       input logic fs);
    logic [4:0] r;
    r = fs ? ({1'b0, fy} + 5'd16 - {1'b0, fb}) : ({1'b0, fy} + {1'b0, fb});
    return r[3:0];
  endfunction

  // Records this cycle's handshakes against the scoreboard, then advances one clock.
  task automatic tick();
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(y, b, sel));
      in_n++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("stream_a", int'(a), int'(exp_q.pop_front()));
      end
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      out_n++;
    end
    @(negedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vecs[0] = '{y: 4'd6,  b: 4'd2, sel: 1'b1, a: 4'd4};
    vecs[1] = '{y: 4'd2,  b: 4'd2, sel: 1'b0, a: 4'd4};
    vecs[2] = '{y: 4'd10, b: 4'd3, sel: 1'b1, a: 4'd7};
    vecs[3] = '{y: 4'd4,  b: 4'd3, sel: 1'b0, a: 4'd7};
    vecs[4] = '{y: 4'd1,  b: 4'd3, sel: 1'b1, a: 4'd14};
    vecs[5] = '{y: 4'd15, b: 4'd2, sel: 1'b0, a: 4'd1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    y = '0; b = '0; sel = 1'b0;
    out_n = 0; in_n = 0; cyc = 0; first_out = -1; last_out = -1;

    // Reset state
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_a", int'(a), 0);
    check("rst_cnt", int'(txn_cnt), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Directed vectors: valid output two cycles after presentation
    for (int i = 0; i < 6; i++) begin
      y = vecs[i].y; b = vecs[i].b; sel = vecs[i].sel; in_valid = 1'b1;
      #1;
      check("vec_in_ready", int'(in_ready), 1);
      @(negedge clk); #1;
      in_valid = 1'b0;
      check("vec_not_early", int'(out_valid), 0);
      @(negedge clk); #1;
      check("vec_out_valid", int'(out_valid), 1);
      check("vec_a", int'(a), int'(vecs[i].a));
    end
    @(negedge clk); #1;
    check("vec_cnt", int'(txn_cnt), 6);
    check("vec_drained", int'(out_valid), 0);

    // Backpressure: two entries buffered, third refused, then drained in order
    out_ready = 1'b0;
    y = vecs[0].y; b = vecs[0].b; sel = vecs[0].sel; in_valid = 1'b1;
    #1;
    check("bp_accept0", int'(in_ready), 1);
    @(negedge clk); #1;
    y = vecs[1].y; b = vecs[1].b; sel = vecs[1].sel;
    #1;
    check("bp_accept1", int'(in_ready), 1);
    @(negedge clk); #1;
    y = vecs[2].y; b = vecs[2].b; sel = vecs[2].sel;
    #1;
    check("bp_full_in_ready", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_a_first", int'(a), 4);
    @(negedge clk); #1;
    check("bp_still_full", int'(in_ready), 0);
    check("bp_a_stable", int'(a), 4);
    check("bp_valid_stable", int'(out_valid), 1);
    check("bp_cnt_hold", int'(txn_cnt), 6);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", int'(in_ready), 1);
    @(negedge clk); #1;
    in_valid = 1'b0;
    check("bp_a_second", int'(a), 4);
    check("bp_cnt7", int'(txn_cnt), 7);
    @(negedge clk); #1;
    check("bp_a_third", int'(a), 7);
    check("bp_cnt8", int'(txn_cnt), 8);
    @(negedge clk); #1;
    check("bp_empty", int'(out_valid), 0);
    check("bp_cnt9", int'(txn_cnt), 9);

    // Reset with two entries buffered
    out_ready = 1'b0;
    y = vecs[0].y; b = vecs[0].b; sel = vecs[0].sel; in_valid = 1'b1;
    @(negedge clk); #1;
    y = vecs[3].y; b = vecs[3].b; sel = vecs[3].sel;
    @(negedge clk); #1;
    in_valid = 1'b0;
    check("mid_buffered", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_cnt", int'(txn_cnt), 0);
    check("mid_rst_a", int'(a), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("mid_no_stale", int'(out_valid), 0);
    end
    check("mid_cnt_zero", int'(txn_cnt), 0);

    // Streaming: 20 back-to-back transactions
    exp_q.delete();
    out_n = 0; in_n = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      y = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); sel = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("stream_in_count", in_n, 20);
    check("stream_out_count", out_n, 20);
    check("stream_consecutive", last_out - first_out, 19);
    check("stream_cnt", int'(txn_cnt), 20);

    // Random ready/valid up to 256 total handshakes: counter wraps to 0
    begin
      int budget;
      budget = 0;
      while (out_n < 256 && budget < 4000) begin
        in_valid = (in_n < 256) ? 1'($urandom_range(0, 1)) : 1'b0;
        y = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); sel = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        tick();
        budget++;
      end
      check("wrap_done_in_budget", int'(budget < 4000), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("wrap_out_count", out_n, 256);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_cnt_zero", int'(txn_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
